// File: rtl/switch_bank_peripheral.sv
// Debounced switch bank with STATE/CHANGE(W1C)/MASK registers on a shared 8-bit bus; raw-to-STATE 2+DEBOUNCE_CYCLES cycles.
// Reads drive BUS_DATA one cycle after the address, with no backpressure; IRQ is a registered OR of enabled change flags.
module switch_bank_peripheral #(
  parameter logic [7:0]  BASE_ADDR       = 8'hA8,
  parameter int          NUM_SW          = 8,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic              CLK,
  input  logic              RESET,
  inout  wire  [7:0]        BUS_DATA,
  input  logic [7:0]        BUS_ADDR,
  input  logic              BUS_WE,
  input  logic [NUM_SW-1:0] SWITCH_IN,
  output logic              IRQ
);

  localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

  logic [NUM_SW-1:0] sync1_q, sync1_d;
  logic [NUM_SW-1:0] sync2_q, sync2_d;
  logic [NUM_SW-1:0] state_q, state_d;
  logic [NUM_SW-1:0] change_q, change_d;
  logic [NUM_SW-1:0] mask_q, mask_d;
  logic [15:0]       cnt_q [NUM_SW];
  logic [15:0]       cnt_d [NUM_SW];
  logic              drv_q, drv_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              irq_q, irq_d;

  logic [7:0]        offset;
  logic              rd_hit;
  logic              wr_change;
  logic              wr_mask;
  logic [NUM_SW-1:0] event_set;
  logic [7:0]        state_ext;
  logic [7:0]        change_ext;
  logic [7:0]        mask_ext;

  always_comb begin
    offset    = BUS_ADDR - BASE_ADDR;
    rd_hit    = !BUS_WE && (offset < 8'd3);
    wr_change = BUS_WE && (offset == 8'd1);
    wr_mask   = BUS_WE && (offset == 8'd2);

    sync1_d   = SWITCH_IN;
    sync2_d   = sync1_q;
    state_d   = state_q;
    event_set = '0;

    // A channel only counts while its synchronised level disagrees with STATE.
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = 16'd0;
      if (sync2_q[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_d[i]   = ~state_q[i];
          event_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end

    // A debounce event in the same cycle as a clearing write keeps the flag set.
    change_d = change_q;
    if (wr_change) begin
      change_d = change_q & ~BUS_DATA[NUM_SW-1:0];
    end
    change_d = change_d | event_set;

    mask_d = wr_mask ? BUS_DATA[NUM_SW-1:0] : mask_q;

    state_ext                = '0;
    state_ext[NUM_SW-1:0]    = state_q;
    change_ext               = '0;
    change_ext[NUM_SW-1:0]   = change_q;
    mask_ext                 = '0;
    mask_ext[NUM_SW-1:0]     = mask_q;

    rdata_d = 8'h00;
    if (rd_hit) begin
      case (offset)
        8'd0:    rdata_d = state_ext;
        8'd1:    rdata_d = change_ext;
        default: rdata_d = mask_ext;
      endcase
    end

    drv_d = rd_hit;
    irq_d = |(change_q & mask_q);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= '0;
      change_q <= '0;
      mask_q   <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= 16'd0;
      end
      drv_q    <= 1'b0;
      rdata_q  <= 8'h00;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      change_q <= change_d;
      mask_q   <= mask_d;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      drv_q    <= drv_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign BUS_DATA = drv_q ? rdata_q : 8'hzz;
  assign IRQ      = irq_q;

endmodule

// File: tb/tb_switch_bank_peripheral.sv
// Directed bench for switch_bank_peripheral with DEBOUNCE_CYCLES=4, NUM_SW=8, BASE_ADDR=A8.
// Bus release is observed by driving a known pattern from the bench and reading it back unchanged.
module tb_switch_bank_peripheral;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic [7:0] SWITCH_IN;
  logic       IRQ;
  wire  [7:0] BUS_DATA;

  logic       tb_drv;
  logic [7:0] tb_dat;
  logic [7:0] rd;
  int         checks   = 0;
  int         failures = 0;

  assign BUS_DATA = tb_drv ? tb_dat : 8'hzz;

  switch_bank_peripheral #(
    .BASE_ADDR      (8'hA8),
    .NUM_SW         (8),
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BUS_DATA (BUS_DATA),
    .BUS_ADDR (BUS_ADDR),
    .BUS_WE   (BUS_WE),
    .SWITCH_IN(SWITCH_IN),
    .IRQ      (IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    BUS_ADDR = addr;
    BUS_WE   = 1'b1;
    tb_drv   = 1'b1;
    tb_dat   = data;
    tick();
    check("bus_released_during_write", BUS_DATA, data);
    tb_drv   = 1'b0;
    BUS_WE   = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
    BUS_ADDR = addr;
    BUS_WE   = 1'b0;
    tick();
    data     = BUS_DATA;
    BUS_ADDR = 8'h00;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    RESET     = 1'b0;
    BUS_ADDR  = 8'hA8;
    BUS_WE    = 1'b0;
    SWITCH_IN = 8'h05;
    tb_drv    = 1'b0;
    tb_dat    = 8'h00;
    rd        = 8'h00;

    // Reset state: IRQ low, bus not driven even with a read address present.
    repeat (3) tick();
    check("reset_irq", {7'b0, IRQ}, 8'h00);
    tb_drv = 1'b1;
    tb_dat = 8'hA5;
    #1;
    check("reset_bus_released", BUS_DATA, 8'hA5);
    tb_drv = 1'b0;

    // Switch held high through reset: STATE rises at edge 6, visible on a continuous read at edge 7.
    RESET = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("state_before_rise", BUS_DATA, 8'h00);
    end
    tick();
    check("state_after_rise", BUS_DATA, 8'h05);
    BUS_ADDR = 8'h00;
    tick();
    bus_read(8'hA9, rd);
    check("change_after_rise", rd, 8'h05);
    check("irq_masked_off", {7'b0, IRQ}, 8'h00);
    bus_write(8'hA9, 8'hFF);
    bus_read(8'hA9, rd);
    check("change_w1c_all", rd, 8'h00);

    // Three-cycle glitch on bit 1 must be rejected.
    bus_write(8'hAA, 8'hFF);
    SWITCH_IN = 8'h07;
    repeat (3) tick();
    SWITCH_IN = 8'h05;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("glitch_irq", {7'b0, IRQ}, 8'h00);
    end
    bus_read(8'hA8, rd);
    check("glitch_state", rd, 8'h05);
    bus_read(8'hA9, rd);
    check("glitch_change", rd, 8'h00);

    // Bit 0 low, then a debounced rise with MASK=01 raises IRQ one cycle after CHANGE[0].
    bus_write(8'hAA, 8'h00);
    SWITCH_IN = 8'h04;
    repeat (10) tick();
    bus_read(8'hA8, rd);
    check("state_bit0_fell", rd, 8'h04);
    bus_write(8'hA9, 8'hFF);
    bus_write(8'hAA, 8'h01);
    tick();
    check("irq_idle", {7'b0, IRQ}, 8'h00);
    SWITCH_IN = 8'h05;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("irq_before_event", {7'b0, IRQ}, 8'h00);
    end
    tick();
    check("irq_after_event", {7'b0, IRQ}, 8'h01);
    bus_write(8'hA9, 8'h01);
    check("irq_on_clear_edge", {7'b0, IRQ}, 8'h01);
    tick();
    check("irq_after_clear", {7'b0, IRQ}, 8'h00);
    bus_read(8'hA9, rd);
    check("change_after_clear", rd, 8'h00);

    // Clearing write lands on the very edge that sets CHANGE[3]: the set wins.
    SWITCH_IN = 8'h0D;
    repeat (5) tick();
    bus_write(8'hA9, 8'hFF);
    bus_read(8'hA9, rd);
    check("set_wins_over_w1c", rd, 8'h08);

    // MASK read/write, STATE ignores writes, bus released outside A8..AA.
    bus_write(8'hAA, 8'h3C);
    bus_read(8'hAA, rd);
    check("mask_readback", rd, 8'h3C);
    bus_write(8'hA8, 8'h00);
    bus_read(8'hA8, rd);
    check("state_write_ignored", rd, 8'h0D);
    check("irq_change3_mask3c", {7'b0, IRQ}, 8'h01);
    tb_drv   = 1'b1;
    tb_dat   = 8'hA5;
    BUS_ADDR = 8'hAB;
    tick();
    check("bus_released_addr_ab", BUS_DATA, 8'hA5);
    BUS_ADDR = 8'hA7;
    tick();
    check("bus_released_addr_a7", BUS_DATA, 8'hA5);
    tb_drv   = 1'b0;
    BUS_ADDR = 8'h00;
    tick();

    // Reset two counts into a debounce of bit 2: counting restarts from zero.
    SWITCH_IN = 8'h00;
    repeat (10) tick();
    SWITCH_IN = 8'h04;
    repeat (4) tick();
    RESET = 1'b0;
    tick();
    check("irq_cleared_by_reset", {7'b0, IRQ}, 8'h00);
    RESET    = 1'b1;
    BUS_ADDR = 8'hA8;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("state2_before_rise", BUS_DATA, 8'h00);
    end
    tick();
    check("state2_after_rise", BUS_DATA, 8'h04);
    BUS_ADDR = 8'h00;
    tick();
    bus_read(8'hAA, rd);
    check("mask_after_reset", rd, 8'h00);
    bus_read(8'hA9, rd);
    check("change2_after_reset", rd, 8'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_bank_peripheral.md
SWITCH_BANK_PERIPHERAL -- requirements
Module: switch_bank_peripheral

Interface
REQ-001 Parameter BASE_ADDR, default 8'hA8: bus address of register 0; registers occupy BASE_ADDR..BASE_ADDR+2.
REQ-002 Parameter NUM_SW, default 8: number of switch channels, legal range 1..8.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16'd50000: consecutive stable cycles required to accept a new level, legal range 2..65535.
REQ-004 CLK  input  1  system clock; all state updates on its rising edge.
REQ-005 RESET  input  1  synchronous active-low reset, sampled on rising CLK.
REQ-006 BUS_DATA  inout  8  shared data bus; driven only during a read of this block, otherwise high-impedance.
REQ-007 BUS_ADDR  input  8  bus address.
REQ-008 BUS_WE  input  1  1 = processor write, 0 = read.
REQ-009 SWITCH_IN  input  NUM_SW  raw asynchronous switch levels.
REQ-010 IRQ  output  1  level interrupt request, active high.

Function
REQ-011 Register map: BASE+0 STATE (read-only, debounced levels); BASE+1 CHANGE (read, write-1-to-clear, latched edge flags); BASE+2 MASK (read/write, interrupt enable per channel).
REQ-012 Bits [7:NUM_SW] of every register shall read as 0 and ignore writes.
REQ-013 Each SWITCH_IN bit shall pass through a 2-flop synchroniser before any other use.
REQ-014 Per channel: 16-bit counter; synchronised level equal to STATE bit -> counter cleared to 0.
REQ-015 Synchronised level differs from STATE bit -> counter increments; at count DEBOUNCE_CYCLES-1 the STATE bit toggles, CHANGE bit sets, counter clears, all in the same cycle.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles shall leave STATE and CHANGE unchanged.
REQ-017 Raw-to-STATE latency: exactly 2 (sync) + DEBOUNCE_CYCLES cycles for a clean step.
REQ-018 Write: BUS_WE=1 and BUS_ADDR matching a writable register at a rising CLK edge captures BUS_DATA in that cycle; writes to BASE+0 or unmapped addresses are ignored.
REQ-019 CHANGE write: each bit written 1 clears; bit written 0 unchanged.
REQ-020 Debounce event and W1C on the same bit in the same cycle: set wins (bit reads 1 afterwards).
REQ-021 Read: BUS_WE=0 and BUS_ADDR in BASE..BASE+2 at a rising edge registers the drive enable and the selected register value; BUS_DATA driven the following cycle (1-cycle latency), value frozen for that cycle.
REQ-022 Drive enable shall deassert on the cycle after the address leaves range or BUS_WE rises; never driven while BUS_WE=1 was sampled.
REQ-023 Reading CHANGE shall not modify it.
REQ-024 IRQ shall be registered: IRQ = |(CHANGE & MASK) as of the previous cycle's register values (1-cycle delay).

Reset
REQ-025 With RESET=0 at a rising edge: synchronisers, STATE, CHANGE, MASK, all counters, drive enable and IRQ cleared to 0; BUS_DATA high-impedance next cycle.
REQ-026 After reset, a switch held high shall produce a STATE rise and a CHANGE set after 2+DEBOUNCE_CYCLES cycles (no reset-time snapshot).
REQ-027 Reset asserted mid-debounce shall abandon the count; counting restarts from 0 after release.

Verification (DEBOUNCE_CYCLES=4, NUM_SW=8, BASE_ADDR=8'hA8)
REQ-028 Reset, SWITCH_IN=8'h05 held -> STATE reads 8'h05 and CHANGE 8'h05 from cycle 6 after release; read of A8 returns 8'h05 one cycle after address.
REQ-029 Bit 1 pulses high for 3 cycles -> STATE and CHANGE bit 1 remain 0; IRQ stays 0.
REQ-030 MASK=8'h01, bit 0 debounced rise -> IRQ=1 one cycle after CHANGE[0] sets; write 8'h01 to A9 -> CHANGE[0]=0, IRQ=0 one cycle later.
REQ-031 Write 8'hFF to A9 in the exact cycle CHANGE[3] sets -> CHANGE[3] reads 1, other bits 0.
REQ-032 Write 8'h3C to AA, read AA -> 8'h3C; write to A8 -> STATE unchanged; BUS_DATA Z whenever BUS_WE=1 or address outside A8..AA.
REQ-033 RESET=0 two cycles into a debounce of bit 2 -> after release, STATE[2] rises only 2+4 cycles later.
